// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks the register file and streams (index, value) pairs with a running checksum
module regfile_dump_reader #(
  parameter int NUM_REGS  = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_addr,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);
  localparam logic [4:0] FIRST_IDX = SKIP_ZERO ? 5'd1 : 5'd0;

  state_t     state, state_next;
  logic [4:0] idx;
  logic       handshake;
  logic       bypass;

  assign handshake = out_valid && out_ready;
  // A write landing in the sampling cycle wins over the stale read; $0 is hardwired.
  assign bypass = wr_en && (wr_addr == idx) && (idx != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = FETCH;
      FETCH:   state_next = SEND;
      SEND:    if (handshake) state_next = (idx == LAST_IDX) ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rd_addr = (state == FETCH) ? idx : 5'd0;
    busy    = (state == FETCH) || (state == SEND);
    done    = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= 5'd0;
      out_valid <= 1'b0;
      out_addr  <= 5'd0;
      out_data  <= 32'd0;
      checksum  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            checksum <= 32'd0;
            idx      <= FIRST_IDX;
          end
        end
        FETCH: begin
          out_addr  <= idx;
          out_data  <= bypass ? wr_data : rd_data;
          out_valid <= 1'b1;
        end
        SEND: begin
          if (handshake) begin
            checksum  <= checksum + out_data;
            out_valid <= 1'b0;
            if (idx != LAST_IDX) idx <= idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - randomized self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        reset, start, start2, wr_en, out_ready, out_ready2;
  logic [4:0]  wr_addr, rd_addr, rd_addr2, out_addr, out_addr2;
  logic [31:0] wr_data, rd_data, rd_data2, out_data, out_data2, checksum, checksum2;
  logic        out_valid, out_valid2, busy, busy2, done, done2;

  logic [31:0] regs [32];
  logic [31:0] exp_data [32];
  logic [4:0]  got_addr [$];
  logic [31:0] got_data [$];
  int          checks = 0;
  int          passes = 0;
  int          done_count, done_cycle;

  always #5 clk = ~clk;

  assign rd_data  = regs[rd_addr];
  assign rd_data2 = regs[rd_addr2];

  regfile_dump_reader #(.NUM_REGS(32), .SKIP_ZERO(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
    .busy(busy), .done(done), .checksum(checksum)
  );

  regfile_dump_reader #(.NUM_REGS(32), .SKIP_ZERO(1'b1)) dut_sz (
    .clk(clk), .reset(reset), .start(start2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_addr(out_addr2), .out_data(out_data2),
    .busy(busy2), .done(done2), .checksum(checksum2)
  );

  // Expected dump = current register contents, $0 reads as zero.
  task automatic snapshot_expected();
    for (int i = 0; i < 32; i++) exp_data[i] = (i == 0) ? 32'd0 : regs[i];
  endtask

  // Drives one full dump and checks the stream, checksum, done timing and stall stability.
  // ready_mode: 0 always ready, 1 toggling, 2 random. snoop: 0 none, 1 write $5 in FETCH,
  // 2 write $5 in SEND, 3 write $0 in FETCH.
  task automatic dump_and_check(input string name, input int ready_mode, input int snoop,
                                input bit extra_starts, input int exp_done_cycle);
    int          cyc;
    bit          wrote, stall;
    logic [4:0]  pa;
    logic [31:0] pd, sum;
    got_addr.delete();
    got_data.delete();
    done_count = 0;
    done_cycle = 0;
    wrote = 0;
    start = 1'b1;
    cyc = 1;
    while (cyc < 300 && !(done_count > 0 && cyc > done_cycle + 4)) begin
      if (extra_starts && (cyc == 20 || cyc == 41)) start = 1'b1;
      if (!wrote && ((snoop == 1 && rd_addr == 5'd5) ||
                     (snoop == 2 && out_valid && out_addr == 5'd5) ||
                     (snoop == 3 && cyc == 2))) begin
        wr_en   = 1'b1;
        wr_addr = (snoop == 3) ? 5'd0 : 5'd5;
        wr_data = (snoop == 3) ? 32'hFFFF_FFFF : 32'hDEAD_BEEF;
        wrote   = 1;
      end
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid && out_ready) begin
        got_addr.push_back(out_addr);
        got_data.push_back(out_data);
      end
      stall = out_valid && !out_ready;
      pa = out_addr;
      pd = out_data;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (wr_en && wr_addr != 5'd0) regs[wr_addr] = wr_data;
      wr_en = 1'b0;
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_addr !== pa || out_data !== pd)
          $display("FAIL %s stall_stable: got v=%b a=%0d d=%h want v=1 a=%0d d=%h",
                   name, out_valid, out_addr, out_data, pa, pd);
        else passes++;
      end
      if (done) begin
        done_count++;
        done_cycle = cyc;
        checks++;
        if (busy !== 1'b0) $display("FAIL %s busy_with_done: busy=%b want 0", name, busy);
        else passes++;
      end
      if (cyc == 2) begin
        checks++;
        if (checksum !== 32'd0) $display("FAIL %s checksum_clear: got %h want 0", name, checksum);
        else passes++;
      end
    end
    checks++;
    if (done_count !== 1) $display("FAIL %s done_pulses: got %0d want 1", name, done_count);
    else passes++;
    if (exp_done_cycle > 0) begin
      checks++;
      if (done_cycle !== exp_done_cycle)
        $display("FAIL %s done_cycle: got %0d want %0d", name, done_cycle, exp_done_cycle);
      else passes++;
    end
    checks++;
    if (got_addr.size() !== 32) $display("FAIL %s pair_count: got %0d want 32", name, got_addr.size());
    else passes++;
    sum = 32'd0;
    for (int i = 0; i < 32; i++) begin
      sum = sum + exp_data[i];
      if (i < got_addr.size()) begin
        checks++;
        if (got_addr[i] !== 5'(i) || got_data[i] !== exp_data[i])
          $display("FAIL %s pair[%0d]: got (%0d,%h) want (%0d,%h)",
                   name, i, got_addr[i], got_data[i], i, exp_data[i]);
        else passes++;
      end
    end
    checks++;
    if (checksum !== sum) $display("FAIL %s checksum: got %h want %h", name, checksum, sum);
    else passes++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || checksum !== 32'd0 ||
        rd_addr !== 5'd0 || out_addr !== 5'd0 || out_data !== 32'd0)
      $display("FAIL reset_state: v=%b busy=%b done=%b cs=%h ra=%0d oa=%0d od=%h want all zero",
               out_valid, busy, done, checksum, rd_addr, out_addr, out_data);
    else passes++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * 32'h1111_1111;
    snapshot_expected();
    dump_and_check("basic", 0, 0, 0, 66);
    repeat (5) @(negedge clk);
    checks++;
    if (checksum !== 32'hF0F0_F0F0 * 32'd0 + 32'(496) * 32'h1111_1111)
      $display("FAIL checksum_hold: got %h want %h", checksum, 32'(496) * 32'h1111_1111);
    else passes++;
  endtask

  task automatic test_toggle_ready();
    snapshot_expected();
    dump_and_check("toggle", 1, 0, 0, 0);
  endtask

  task automatic test_random_ready();
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    snapshot_expected();
    dump_and_check("random", 2, 0, 0, 0);
  endtask

  task automatic test_snoop_fetch();
    snapshot_expected();
    exp_data[5] = 32'hDEAD_BEEF;
    dump_and_check("snoop_fetch", 2, 1, 0, 0);
  endtask

  task automatic test_snoop_send();
    regs[5] = $urandom;
    snapshot_expected();
    dump_and_check("snoop_send", 0, 2, 0, 66);
  endtask

  task automatic test_zero_write();
    snapshot_expected();
    dump_and_check("zero_write", 0, 3, 0, 66);
  endtask

  task automatic test_reset_mid();
    int n;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_addr == 5'd10) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) $display("FAIL reset_mid_reach: idx 10 never sent within %0d cycles", n);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || checksum !== 32'd0)
      $display("FAIL reset_mid: v=%b busy=%b cs=%h want 0 0 0", out_valid, busy, checksum);
    else passes++;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid_quiet: v=%b done=%b want 0 0", out_valid, done);
    else passes++;
    snapshot_expected();
    dump_and_check("after_reset", 0, 0, 0, 66);
  endtask

  task automatic test_start_while_busy();
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    snapshot_expected();
    dump_and_check("busy_start", 2, 0, 1, 0);
  endtask

  task automatic test_skip_zero();
    int cyc, dcount, dcyc;
    logic [31:0] sum;
    logic [4:0]  ga [$];
    logic [31:0] gd [$];
    snapshot_expected();
    out_ready2 = 1'b1;
    start2 = 1'b1;
    cyc = 1;
    dcount = 0;
    dcyc = 0;
    while (cyc < 120) begin
      if (out_valid2) begin
        ga.push_back(out_addr2);
        gd.push_back(out_data2);
      end
      @(negedge clk);
      cyc++;
      start2 = 1'b0;
      if (done2) begin
        dcount++;
        dcyc = cyc;
      end
    end
    checks++;
    if (dcount !== 1 || dcyc !== 64)
      $display("FAIL skip_zero_done: pulses=%0d cycle=%0d want 1 at 64", dcount, dcyc);
    else passes++;
    checks++;
    if (ga.size() !== 31) $display("FAIL skip_zero_count: got %0d want 31", ga.size());
    else passes++;
    sum = 32'd0;
    for (int i = 1; i < 32; i++) begin
      sum = sum + exp_data[i];
      if (i - 1 < ga.size()) begin
        checks++;
        if (ga[i-1] !== 5'(i) || gd[i-1] !== exp_data[i])
          $display("FAIL skip_zero_pair[%0d]: got (%0d,%h) want (%0d,%h)",
                   i - 1, ga[i-1], gd[i-1], i, exp_data[i]);
        else passes++;
      end
    end
    checks++;
    if (checksum2 !== sum) $display("FAIL skip_zero_checksum: got %h want %h", checksum2, sum);
    else passes++;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    wr_en = 1'b0;
    wr_addr = 5'd0;
    wr_data = 32'd0;
    out_ready = 1'b0;
    out_ready2 = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_toggle_ready();
    test_random_ready();
    test_snoop_fetch();
    test_snoop_send();
    test_zero_write();
    test_reset_mid();
    test_start_while_busy();
    test_skip_zero();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side companion to the CPU's 32x32 register file.
- On a start pulse it walks register indices through one regfile read port and streams each (index, value) pair out over a valid/ready interface.
- It also accumulates a 32-bit checksum of the streamed values.
- It snoops the writeback port so that a write landing in the sampling cycle is reflected in the dump. Used for end-of-test state dumps and bench comparison.

Parameters:
- NUM_REGS, 32, number of registers walked (indices 0..NUM_REGS-1).
- SKIP_ZERO, 0, when 1 the walk starts at index 1 and $0 is not emitted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- start  in  1  request a dump; accepted only in IDLE
- rd_addr  out  5  address to regfile read port (combinationally read)
- rd_data  in  32  regfile read data for rd_addr
- wr_en  in  1  writeback snoop: regfile write enable
- wr_addr  in  5  writeback snoop: destination register
- wr_data  in  32  writeback snoop: write data
- out_valid  out  1  streamed pair valid
- out_ready  in  1  consumer ready
- out_addr  out  5  register index of streamed pair
- out_data  out  32  register value of streamed pair
- busy  out  1  high in FETCH/SEND
- done  out  1  one-cycle pulse when the last pair is accepted
- checksum  out  32  running sum of accepted out_data, mod 2^32

Behaviour:
- Reset values: state IDLE, idx 0, rd_addr 0, out_valid 0, out_addr 0, out_data 0, busy 0, done 0, checksum 0. Reset mid-dump aborts immediately; no further out_valid.
- States are IDLE, FETCH, SEND, DONE.
- IDLE:
  - rd_addr = 0.
  - On start=1: clear checksum, set idx = SKIP_ZERO ? 1 : 0, go to FETCH.
- FETCH (1 cycle):
  - rd_addr = idx.
  - Capture out_addr <= idx.
  - Capture out_data <= (wr_en && wr_addr==idx && idx!=0) ? wr_data : rd_data. This write bypass gives post-write value semantics; $0 always reads rd_data.
  - Set out_valid <= 1 and go to SEND.
- SEND:
  - out_valid = 1. out_addr and out_data stay stable until handshake (out_valid && out_ready).
  - Snoop writes during SEND do not alter the captured value (snapshot at FETCH).
  - On handshake: checksum <= checksum + out_data; out_valid <= 0.
  - If idx == NUM_REGS-1, go to DONE. Otherwise idx <= idx+1 and go to FETCH.
- DONE (1 cycle): done = 1, then go to IDLE.
- checksum holds its value after DONE until the next accepted start.
- start is ignored outside IDLE and is not queued.
- Throughput: 2 cycles per register with out_ready held high. Full dump of 32 registers = 1 (accept) + 64 + 1 (DONE) cycles from start to done.
- busy = (state==FETCH || state==SEND). done and busy are never high together.
- Checksum adds wrap mod 2^32; no overflow flag.
- out_valid never drops without a handshake except on reset.

Test Plan:
- Reset, preload regfile with reg[i]=i*0x11111111 (mod 2^32), pulse start, out_ready=1 -> 32 pairs in order 0..31 with matching data; done pulses exactly 66 cycles after start is sampled. checksum = sum of all values mod 2^32.
- Same preload, out_ready toggling 1/0 every cycle -> identical stream and checksum; out_addr and out_data stable whenever out_valid=1 and out_ready=0.
- During FETCH of idx 5, drive wr_en=1, wr_addr=5, wr_data=0xDEADBEEF -> pair (5, 0xDEADBEEF). Same write during SEND of idx 5 -> pair carries the old value.
- Write of 0xFFFFFFFF to $0 during FETCH of idx 0 -> pair (0, 0x00000000). With SKIP_ZERO=1 -> first pair is index 1, 31 pairs total.
- Assert reset while in SEND of idx 10 -> next cycle out_valid=0, busy=0, checksum=0. A new start gives a full dump from idx 0.
- Pulse start while busy -> ignored: stream unchanged, single done pulse. After done, checksum holds until the next start, which clears it.
